// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Holds the widths, reset/bubble constants and fetch FSM encodings.
package pipe_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam logic [15:0] NOP_INSTR = 16'h0800;

   typedef logic [1:0] fetchStateT;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   // What the IF/ID latch loads on the coming edge
   typedef logic [1:0] ifidSelT;

   localparam logic [1:0] IFID_HOLD   = 2'd0;
   localparam logic [1:0] IFID_MEM    = 2'd1;
   localparam logic [1:0] IFID_SKID   = 2'd2;
   localparam logic [1:0] IFID_BUBBLE = 2'd3;

endpackage

// File: rtl/fetch_ifid_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
// A request stays asserted with a stable address until imem_done.
interface fetch_ifid_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);

   logic               imem_rd;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               imem_done;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_data,
      input  imem_done
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_data,
      output imem_done
   );

endinterface

// File: rtl/pc_reg.sv
// Program counter with load (redirect), increment by 2 and hold.
// Load wins over increment; PC+2 wraps modulo 2^ADDR_W.
module pc_reg #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pcPlus2
);

   assign pcPlus2 = pc + ADDR_W'(2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (inc) begin
         pc <= pcPlus2;
      end
   end

endmodule

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, talks to instruction memory and applies stall, flush, redirect and halt.
module fetch_ifid #(
   parameter int                 ADDR_W    = pipe_pkg::ADDR_W,
   parameter int                 INSTR_W   = pipe_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC  = pipe_pkg::RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stallCtrl,
   input  logic                jumpFlush,
   input  logic                Jump_IDEX,
   input  logic [ADDR_W-1:0]   jumpTarget_IDEX,
   input  logic                takeBranch_EXMEM,
   input  logic [ADDR_W-1:0]   branchTarget_EXMEM,
   input  logic                halt_ID,
   fetch_ifid_if.master        imem,
   output logic [INSTR_W-1:0]  Instr_IFID,
   output logic [ADDR_W-1:0]   PCinc_IFID,
   output logic                valid_IFID,
   output logic                fetchBusy,
   output logic                halted
);

   import pipe_pkg::*;

   fetchStateT         state;
   fetchStateT         stateNext;
   ifidSelT            ifidSel;
   logic               discard;
   logic               discardNext;
   logic               pcLoad;
   logic               pcInc;
   logic               reqLoad;
   logic               skidLoad;
   logic               redirect;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pcPlus2;
   logic [ADDR_W-1:0]  pcTarget;
   logic [ADDR_W-1:0]  reqAddr;
   logic [INSTR_W-1:0] skidData;

   // A taken branch is older than a jump, so its target wins.
   assign redirect = takeBranch_EXMEM | Jump_IDEX;
   assign pcTarget = takeBranch_EXMEM ? branchTarget_EXMEM : jumpTarget_IDEX;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) pcReg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (pcLoad),
      .inc     (pcInc),
      .target  (pcTarget),
      .pc      (pc),
      .pcPlus2 (pcPlus2)
   );

   // While a request is outstanding the bus keeps the captured address, so a
   // redirect can move the PC immediately without disturbing the memory.
   assign imem.imem_rd   = rst_n && ((state == ST_FETCH) || (state == ST_WAIT));
   assign imem.imem_addr = (state == ST_WAIT) ? reqAddr : pc;
   assign fetchBusy      = imem.imem_rd && !imem.imem_done;
   assign halted         = (state == ST_HALT);

   // Next-state and datapath control, in priority order redirect > halt > stall > normal.
   always_comb begin
      stateNext   = state;
      discardNext = discard;
      pcLoad      = 1'b0;
      pcInc       = 1'b0;
      reqLoad     = 1'b0;
      skidLoad    = 1'b0;
      ifidSel     = IFID_HOLD;

      case (state)
         ST_FETCH, ST_WAIT: begin
            if (redirect) begin
               pcLoad  = 1'b1;
               ifidSel = IFID_BUBBLE;
               if (imem.imem_done) begin
                  stateNext   = ST_FETCH;
                  discardNext = 1'b0;
               end else begin
                  stateNext   = ST_WAIT;
                  discardNext = 1'b1;
                  reqLoad     = (state == ST_FETCH);
               end
            end else if (halt_ID) begin
               stateNext   = ST_HALT;
               discardNext = 1'b0;
               ifidSel     = IFID_BUBBLE;
            end else if (!imem.imem_done) begin
               stateNext = ST_WAIT;
               reqLoad   = (state == ST_FETCH);
               if (!stallCtrl) begin
                  ifidSel = IFID_BUBBLE;
               end
            end else if (discard) begin
               stateNext   = ST_FETCH;
               discardNext = 1'b0;
               if (!stallCtrl) begin
                  ifidSel = IFID_BUBBLE;
               end
            end else if (stallCtrl) begin
               skidLoad  = 1'b1;
               stateNext = ST_HOLD;
            end else begin
               ifidSel   = IFID_MEM;
               pcInc     = 1'b1;
               stateNext = ST_FETCH;
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               pcLoad    = 1'b1;
               ifidSel   = IFID_BUBBLE;
               stateNext = ST_FETCH;
            end else if (halt_ID) begin
               ifidSel   = IFID_BUBBLE;
               stateNext = ST_HALT;
            end else if (!stallCtrl) begin
               ifidSel   = IFID_SKID;
               pcInc     = 1'b1;
               stateNext = ST_FETCH;
            end
         end

         ST_HALT: begin
            if (takeBranch_EXMEM) begin
               pcLoad    = 1'b1;
               ifidSel   = IFID_BUBBLE;
               stateNext = ST_FETCH;
            end
         end

         default: begin
            stateNext = ST_FETCH;
         end
      endcase

      if (jumpFlush) begin
         ifidSel = IFID_BUBBLE;
      end
   end

   // FSM state, pending-discard flag, captured request address and skid buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_FETCH;
         discard  <= 1'b0;
         reqAddr  <= '0;
         skidData <= '0;
      end else begin
         state   <= stateNext;
         discard <= discardNext;
         if (reqLoad) begin
            reqAddr <= pc;
         end
         if (skidLoad) begin
            skidData <= imem.imem_data;
         end
      end
   end

   // IF/ID latch; a bubble only clears the instruction and valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Instr_IFID <= NOP_INSTR;
         PCinc_IFID <= '0;
         valid_IFID <= 1'b0;
      end else begin
         case (ifidSel)
            IFID_MEM: begin
               Instr_IFID <= imem.imem_data;
               PCinc_IFID <= pcPlus2;
               valid_IFID <= 1'b1;
            end
            IFID_SKID: begin
               Instr_IFID <= skidData;
               PCinc_IFID <= pcPlus2;
               valid_IFID <= 1'b1;
            end
            IFID_BUBBLE: begin
               Instr_IFID <= NOP_INSTR;
               valid_IFID <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: scripted per-cycle stimulus pushes expected post-edge
// outputs to a queue, a monitor pops and compares them after each rising edge.
module tb_fetch_ifid;

   localparam int DC = -1;

   typedef struct {
      string tag;
      int    addr;
      int    rd;
      int    instr;
      int    pcinc;
      int    valid;
      int    busy;
      int    halted;
   } expT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stallCtrl;
   logic        jumpFlush;
   logic        Jump_IDEX;
   logic [15:0] jumpTarget_IDEX;
   logic        takeBranch_EXMEM;
   logic [15:0] branchTarget_EXMEM;
   logic        halt_ID;
   logic [15:0] Instr_IFID;
   logic [15:0] PCinc_IFID;
   logic        valid_IFID;
   logic        fetchBusy;
   logic        halted;

   int  errors = 0;
   int  checks = 0;
   int  memLat = 0;
   int  waitCnt = 0;
   expT expQ[$];

   fetch_ifid_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

   fetch_ifid #(
      .ADDR_W    (16),
      .INSTR_W   (16),
      .RESET_PC  (16'h0000),
      .NOP_INSTR (16'h0800)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .stallCtrl          (stallCtrl),
      .jumpFlush          (jumpFlush),
      .Jump_IDEX          (Jump_IDEX),
      .jumpTarget_IDEX    (jumpTarget_IDEX),
      .takeBranch_EXMEM   (takeBranch_EXMEM),
      .branchTarget_EXMEM (branchTarget_EXMEM),
      .halt_ID            (halt_ID),
      .imem               (bus),
      .Instr_IFID         (Instr_IFID),
      .PCinc_IFID         (PCinc_IFID),
      .valid_IFID         (valid_IFID),
      .fetchBusy          (fetchBusy),
      .halted             (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] memData(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h1111;
         16'h0002: return 16'h2222;
         default:  return a;
      endcase
   endfunction

   // Memory with programmable latency: done after memLat extra cycles of request
   assign bus.imem_done = bus.imem_rd && (waitCnt >= memLat);
   assign bus.imem_data = memData(bus.imem_addr);

   always @(posedge clk) begin
      waitCnt <= (bus.imem_rd && !bus.imem_done) ? waitCnt + 1 : 0;
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".rd"},     int'(bus.imem_rd), 0);
      checkOutput({tag, ".addr"},   int'(bus.imem_addr), 'h0000);
      checkOutput({tag, ".instr"},  int'(Instr_IFID), 'h0800);
      checkOutput({tag, ".pcinc"},  int'(PCinc_IFID), 0);
      checkOutput({tag, ".valid"},  int'(valid_IFID), 0);
      checkOutput({tag, ".busy"},   int'(fetchBusy), 0);
      checkOutput({tag, ".halted"}, int'(halted), 0);
   endtask

   // Drive one cycle of inputs, queue what must be visible after the edge, advance.
   task automatic applyStimulus(input string tag,
                                input logic st, input logic fl,
                                input logic jp, input logic [15:0] jt,
                                input logic br, input logic [15:0] bt,
                                input logic hl,
                                input int eAddr, input int eRd, input int eInstr,
                                input int ePcinc, input int eValid,
                                input int eBusy, input int eHalted);
      expT e;
      stallCtrl          = st;
      jumpFlush          = fl;
      Jump_IDEX          = jp;
      jumpTarget_IDEX    = jt;
      takeBranch_EXMEM   = br;
      branchTarget_EXMEM = bt;
      halt_ID            = hl;
      e.tag    = tag;
      e.addr   = eAddr;
      e.rd     = eRd;
      e.instr  = eInstr;
      e.pcinc  = ePcinc;
      e.valid  = eValid;
      e.busy   = eBusy;
      e.halted = eHalted;
      expQ.push_back(e);
      @(negedge clk);
   endtask

   initial begin : monitorProc
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.addr   >= 0) checkOutput({e.tag, ".addr"},   int'(bus.imem_addr), e.addr);
            if (e.rd     >= 0) checkOutput({e.tag, ".rd"},     int'(bus.imem_rd), e.rd);
            if (e.instr  >= 0) checkOutput({e.tag, ".instr"},  int'(Instr_IFID), e.instr);
            if (e.pcinc  >= 0) checkOutput({e.tag, ".pcinc"},  int'(PCinc_IFID), e.pcinc);
            if (e.valid  >= 0) checkOutput({e.tag, ".valid"},  int'(valid_IFID), e.valid);
            if (e.busy   >= 0) checkOutput({e.tag, ".busy"},   int'(fetchBusy), e.busy);
            if (e.halted >= 0) checkOutput({e.tag, ".halted"}, int'(halted), e.halted);
         end
      end
   end

   initial begin
      rst_n              = 1'b0;
      stallCtrl          = 1'b0;
      jumpFlush          = 1'b0;
      Jump_IDEX          = 1'b0;
      jumpTarget_IDEX    = 16'h0000;
      takeBranch_EXMEM   = 1'b0;
      branchTarget_EXMEM = 16'h0000;
      halt_ID            = 1'b0;
      #12;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("release.rd", int'(bus.imem_rd), 1);
      checkOutput("release.addr", int'(bus.imem_addr), 'h0000);

      //            tag          st fl jp jt       br bt       hl addr    rd instr    pcinc  val busy halt
      applyStimulus("seq0",      0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0002, 1, 'h1111, 'h0002, 1, DC, 0);
      applyStimulus("seq1",      0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0004, 1, 'h2222, 'h0004, 1, DC, 0);
      applyStimulus("seq2",      0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0006, 1, 'h0004, 'h0006, 1, DC, 0);
      applyStimulus("stall0",    1, 0, 0, 16'h0,   0, 16'h0,   0, 'h0006, 0, 'h0004, 'h0006, 1, DC, 0);
      applyStimulus("stall1",    1, 0, 0, 16'h0,   0, 16'h0,   0, 'h0006, 0, 'h0004, 'h0006, 1, DC, 0);
      applyStimulus("stall2",    1, 0, 0, 16'h0,   0, 16'h0,   0, 'h0006, 0, 'h0004, 'h0006, 1, DC, 0);
      applyStimulus("unstall",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0008, 1, 'h0006, 'h0008, 1, DC, 0);
      applyStimulus("seq3",      0, 0, 0, 16'h0,   0, 16'h0,   0, 'h000A, 1, 'h0008, 'h000A, 1, DC, 0);
      applyStimulus("jump",      0, 1, 1, 16'h40,  0, 16'h0,   0, 'h0040, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("jumpTgt",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0042, 1, 'h0040, 'h0042, 1, DC, 0);
      applyStimulus("brVsJmp",   0, 0, 1, 16'h200, 1, 16'h100, 0, 'h0100, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("brTgt",     0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0102, 1, 'h0100, 'h0102, 1, DC, 0);
      applyStimulus("jmpVsStl",  1, 0, 1, 16'h30,  0, 16'h0,   0, 'h0030, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("jmpTgt2",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0032, 1, 'h0030, 'h0032, 1, DC, 0);
      applyStimulus("flushHold", 1, 1, 0, 16'h0,   0, 16'h0,   0, 'h0032, 0, 'h0800, DC,     0, DC, 0);
      applyStimulus("holdRel",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0034, 1, 'h0032, 'h0034, 1, DC, 0);

      memLat = 2;
      applyStimulus("wait0",     0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0034, 1, 'h0800, DC,     0, 1,  0);
      applyStimulus("waitBr",    0, 0, 0, 16'h0,   1, 16'h80,  0, 'h0034, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("waitDrop",  0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0080, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("wait80a",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0080, 1, 'h0800, DC,     0, 1,  0);
      applyStimulus("wait80b",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0080, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("got80",     0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0082, 1, 'h0080, 'h0082, 1, DC, 0);

      memLat = 0;
      applyStimulus("brWrap",    0, 0, 0, 16'h0,   1, 16'hFFFE,0, 'hFFFE, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("wrap",      0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0000, 1, 'hFFFE, 'h0000, 1, DC, 0);
      applyStimulus("afterWrap", 0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0002, 1, 'h1111, 'h0002, 1, DC, 0);
      applyStimulus("halt",      0, 0, 0, 16'h0,   0, 16'h0,   1, DC,      0, 'h0800, DC,     0, 0,  1);
      applyStimulus("haltJmp",   0, 0, 1, 16'h10,  0, 16'h0,   0, DC,      0, 'h0800, DC,     0, 0,  1);
      applyStimulus("haltIdle",  0, 0, 0, 16'h0,   0, 16'h0,   0, DC,      0, 'h0800, DC,     0, 0,  1);
      applyStimulus("haltBr",    0, 0, 0, 16'h0,   1, 16'h50,  0, 'h0050, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("brOut",     0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0052, 1, 'h0050, 'h0052, 1, DC, 0);
      applyStimulus("haltVsJmp", 0, 0, 1, 16'h60,  0, 16'h0,   1, 'h0060, 1, 'h0800, DC,     0, DC, 0);
      applyStimulus("jmp60",     0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0062, 1, 'h0060, 'h0062, 1, DC, 0);

      memLat = 2;
      applyStimulus("preRst",    0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0062, 1, 'h0800, DC,     0, 1,  0);
      #2;
      rst_n = 1'b0;
      #1;
      checkReset("midWaitRst");
      @(negedge clk);
      memLat = 0;
      rst_n  = 1'b1;
      applyStimulus("postRst",   0, 0, 0, 16'h0,   0, 16'h0,   0, 'h0002, 1, 'h1111, 'h0002, 1, DC, 0);

      @(negedge clk);
      checkOutput("queueDrained", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
